// File: rtl/spi_axi_pkg.sv
// Shared types and constants for the SPI-to-AXI4-Lite transaction engine.
// The optional SPI_AXI_TXN_STATS_EN build uses sat_inc16 for its counter bank.
package spi_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4
  } txn_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic [3:0] AXI_STRB_DEFAULT = 4'hF;

  // Holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
    if (inc && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/spi_axi_txn_stats.sv
// Saturating completion/error counter bank for the transaction engine.
// Present only when SPI_AXI_TXN_STATS_EN is defined.
`ifdef SPI_AXI_TXN_STATS_EN
module spi_axi_txn_stats
  import spi_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc_wr,
  input  logic        inc_rd,
  input  logic        inc_err,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] err_cnt
);

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_cnt  <= 16'd0;
      rd_cnt  <= 16'd0;
      err_cnt <= 16'd0;
    end else begin
      wr_cnt  <= sat_inc16(wr_cnt, inc_wr);
      rd_cnt  <= sat_inc16(rd_cnt, inc_rd);
      err_cnt <= sat_inc16(err_cnt, inc_err);
    end
  end

endmodule
`endif

// File: rtl/spi_axi_lite_master_txn.sv
// AXI4-Lite single-beat master driven by the SPI-slave FSM init/done handshake.
// Define SPI_AXI_TXN_STATS_EN to add the stat_* counter ports.
module spi_axi_lite_master_txn
  import spi_axi_pkg::*;
#(
  parameter int          SPI_ADDR_WIDTH = 20,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h4000_0000
) (
  input  logic                      core_clk,
  input  logic                      core_reset,
  input  logic                      init_w_axi_txn,
  input  logic                      init_r_axi_txn,
  input  logic [SPI_ADDR_WIDTH-1:0] user_awaddr,
  input  logic [SPI_ADDR_WIDTH-1:0] user_araddr,
  input  logic [31:0]               user_wdata,
  output logic [31:0]               user_rdata,
  output logic                      done_w_axi_txn,
  output logic                      done_r_axi_txn,
  output logic                      error_w_axi_txn,
  output logic                      error_r_axi_txn,
`ifdef SPI_AXI_TXN_STATS_EN
  input  logic                      stat_clr,
  output logic [15:0]               stat_wr_cnt,
  output logic [15:0]               stat_rd_cnt,
  output logic [15:0]               stat_err_cnt,
`endif
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  txn_state_e                state;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr;
  logic                      aw_done;
  logic                      w_done;
  logic                      wr_complete;
  logic                      rd_complete;
  logic                      unused_resp_bits;

  // User address is zero-extended, offset by the base, and truncated to the bus width.
  assign wr_addr = AXI_ADDR_WIDTH'(AXI_BASE_ADDR) + AXI_ADDR_WIDTH'(user_awaddr);
  assign rd_addr = AXI_ADDR_WIDTH'(AXI_BASE_ADDR) + AXI_ADDR_WIDTH'(user_araddr);

  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;
  assign m_axi_wstrb  = AXI_STRB_DEFAULT;

  // A channel counts as done once it has handshaken, either earlier or this cycle.
  assign aw_done     = !m_axi_awvalid || m_axi_awready;
  assign w_done      = !m_axi_wvalid  || m_axi_wready;
  assign wr_complete = (state == ST_WR_RESP) && m_axi_bvalid;
  assign rd_complete = (state == ST_RD_DATA) && m_axi_rvalid;

  // Only bit 1 of a response distinguishes error from success.
  assign unused_resp_bits = m_axi_bresp[0] ^ m_axi_rresp[0];

  // Transaction FSM and all registered outputs.
  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      state           <= ST_IDLE;
      m_axi_awaddr    <= {AXI_ADDR_WIDTH{1'b0}};
      m_axi_awvalid   <= 1'b0;
      m_axi_wdata     <= 32'd0;
      m_axi_wvalid    <= 1'b0;
      m_axi_bready    <= 1'b0;
      m_axi_araddr    <= {AXI_ADDR_WIDTH{1'b0}};
      m_axi_arvalid   <= 1'b0;
      m_axi_rready    <= 1'b0;
      user_rdata      <= 32'd0;
      done_w_axi_txn  <= 1'b0;
      done_r_axi_txn  <= 1'b0;
      error_w_axi_txn <= 1'b0;
      error_r_axi_txn <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A read wins a same-cycle collision; the write is simply dropped.
          if (init_r_axi_txn) begin
            m_axi_araddr    <= rd_addr;
            m_axi_arvalid   <= 1'b1;
            done_r_axi_txn  <= 1'b0;
            error_r_axi_txn <= 1'b0;
            state           <= ST_RD_ADDR;
          end else if (init_w_axi_txn) begin
            m_axi_awaddr    <= wr_addr;
            m_axi_wdata     <= user_wdata;
            m_axi_awvalid   <= 1'b1;
            m_axi_wvalid    <= 1'b1;
            done_w_axi_txn  <= 1'b0;
            error_w_axi_txn <= 1'b0;
            state           <= ST_WR_ADDR_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (wr_complete) begin
            done_w_axi_txn  <= 1'b1;
            error_w_axi_txn <= m_axi_bresp[1];
            m_axi_bready    <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // Data is captured even when the slave signals an error.
          if (rd_complete) begin
            user_rdata      <= m_axi_rdata;
            done_r_axi_txn  <= 1'b1;
            error_r_axi_txn <= m_axi_rresp[1];
            m_axi_rready    <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_AXI_TXN_STATS_EN
  spi_axi_txn_stats u_stats (
    .clk     (core_clk),
    .reset   (core_reset),
    .clr     (stat_clr),
    .inc_wr  (wr_complete),
    .inc_rd  (rd_complete),
    .inc_err ((wr_complete && m_axi_bresp[1]) || (rd_complete && m_axi_rresp[1])),
    .wr_cnt  (stat_wr_cnt),
    .rd_cnt  (stat_rd_cnt),
    .err_cnt (stat_err_cnt)
  );
`endif

endmodule
